nios_onchip_mem_arbiter: RTL and testbench
==========================================

Name: nios_onchip_mem_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single-port on-chip RAM (32-bit data, 13-bit word address, 5000 words, byte enables, 1-cycle read latency) between the Nios data master (m0) and a DMA/peripheral master (m1).
- Issues at most one RAM access per cycle, stalls the losing requester with waitrequest, and routes read data back with a registered readdatavalid.
- Sits between the interconnect and the RAM's chipselect/write/address/byteenable/clken pins.

Parameters:
- ADDR_W, 13, word address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 5000, implemented words; used only by the optional range check.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- mX_address  in  ADDR_W  requester X word address (X = 0, 1; same set of ports for each requester).
- mX_byteenable  in  DATA_W/8  byte lanes.
- mX_read  in  1  read request.
- mX_write  in  1  write request.
- mX_writedata  in  DATA_W  write data.
- mX_waitrequest  out  1  high = request not accepted this cycle.
- mX_readdata  out  DATA_W  read data.
- mX_readdatavalid  out  1  one-cycle strobe qualifying mX_readdata.
- mem_stall  in  1  blocks all issue (driven from reset_req).
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  DATA_W/8  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  to RAM; equals ~mem_stall.
- mem_readdata  in  DATA_W  from RAM, valid one cycle after a read is issued.
- err_irq  out  1  sticky range-error flag (optional feature only; otherwise tied 0).

Behaviour:
- Request: reqX = mX_read | mX_write. mX_read and mX_write both high is illegal; treat it as a write.
- Arbitration:
  - Combinational, within the cycle. Round-robin pointer last_gnt is reset to 1, so m0 wins the first contention.
  - Only one requester: it wins. Both requesting: the one not equal to last_gnt wins.
  - last_gnt updates to the winner on every issued access.
  - mem_stall=1: nothing is issued, both waitrequests are high, last_gnt holds.
- Issue:
  - Winner gets mX_waitrequest=0 in the same cycle. mem_chipselect=1; mem_address/byteenable/writedata are muxed from the winner; mem_write=winner's write.
  - Non-winners, and idle requesters, see waitrequest=1.
  - No request: chipselect=0, mem_write=0, address/data held at the m0 mux value.
- Read return:
  - Issued read registers rd_pend=1 and rd_tag=winner. The next cycle, mTAG_readdatavalid=1 and mTAG_readdata=mem_readdata.
  - mX_readdata is driven from mem_readdata for both ports; only readdatavalid is steered.
  - Back-to-back reads, including alternating requesters, give one valid per cycle with no bubble.
- Writes: single-cycle, no response.
- Read in cycle N then write in N+1 to the same address: the read returns the old data.
- Reset (async, reset_n=0):
  - rd_pend=0, both readdatavalid=0, last_gnt=1, err_irq=0.
  - waitrequest outputs are 1 while reset_n=0 (gated by a reset_n-synchronised register).
  - A read in flight when reset asserts is discarded; no valid is produced after release.
- mem_stall asserted with rd_pend=1: the pending valid still fires, because the data was launched before the stall.

Optional Feature:
- Macro: OCM_ARB_RANGE_CHECK_EN.
- Defined:
  - An access with address >= DEPTH is accepted (waitrequest=0) but not issued to RAM: chipselect=0.
  - Reads return 32'hDEADBEEF with normal 1-cycle readdatavalid timing.
  - err_irq is set and stays set until reset.
- Undefined: no check; all addresses go to RAM; err_irq=0.

Decomposition:
- Shared package nios_ocm_pkg holds ADDR_W/DATA_W defaults, DEPTH=5000, the BADDATA constant 32'hDEADBEEF, and the requester-id typedef (1 bit).
- Sub-module nios_rr_arb2: 2-way round-robin grant with a last_gnt register and an update enable. Instantiated once.

Test Plan:
- Single m0 write addr 0x010 data 0xA5A5A5A5 be 4'hF, then m0 read 0x010 -> m0_waitrequest=0 both cycles; m0_readdatavalid one cycle after the read with 0xA5A5A5A5.
- m0 and m1 read simultaneously for 4 cycles (0x020 and 0x030) -> grants alternate m0,m1,m0,m1; valids alternate one cycle later; each master sees 2 waitrequest cycles.
- Byte-lane write be=4'b0010 data 0x0000FF00 over 0x11223344 at 0x040 -> readback 0x1122FF44.
- mem_stall=1 for 3 cycles with m1 reading 0x050 -> m1_waitrequest=1, chipselect=0 throughout; issued on the first cycle after stall drops; valid one cycle later.
- reset_n pulled low the cycle after an m0 read issue -> no m0_readdatavalid; last_gnt=1 after release; next contention is won by m0.
- (OCM_ARB_RANGE_CHECK_EN) m1 read 0x1388 -> chipselect=0, m1_readdata=0xDEADBEEF with valid, err_irq=1 and sticky.

Source files
------------

// File: rtl/nios_ocm_pkg.sv
// Shared definitions for the Nios on-chip RAM arbiter: default widths,
// implemented depth, the out-of-range read pattern and the requester id type.
package nios_ocm_pkg;

  localparam int OCM_ADDR_W = 13;
  localparam int OCM_DATA_W = 32;
  localparam int OCM_DEPTH  = 5000;

  // Returned for reads that fall outside the implemented RAM
  localparam logic [31:0] BADDATA = 32'hDEADBEEF;

  // Requester id: 0 = Nios data master, 1 = DMA/peripheral master
  typedef logic req_id_t;

  localparam req_id_t ID_M0 = 1'b0;
  localparam req_id_t ID_M1 = 1'b1;

endpackage

// File: rtl/nios_rr_arb2.sv
// Two-way round-robin grant. The grant is combinational within the cycle;
// last_gnt remembers the most recent winner and moves only when upd_en
// says the grant was actually taken.
module nios_rr_arb2
  import nios_ocm_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    req0,
  input  logic    req1,
  input  logic    upd_en,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  req_id_t last_gnt_q;
  req_id_t last_gnt_d;

  // Pick the winner: a lone requester wins, on contention the one that did not win last
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = ID_M0;
    if (req0 && req1) begin
      gnt_id = ~last_gnt_q;
    end else if (req1) begin
      gnt_id = ID_M1;
    end else begin
      gnt_id = ID_M0;
    end
  end

  // Pointer follows the winner only on a taken grant
  always_comb begin
    if (upd_en) begin
      last_gnt_d = gnt_id;
    end else begin
      last_gnt_d = last_gnt_q;
    end
  end

  // Pointer register; reset to m1 so m0 wins the first contention
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= ID_M1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// Round-robin arbiter sharing the single-port on-chip RAM between the Nios
// data master (m0) and a DMA/peripheral master (m1). One access per cycle,
// loser stalled by waitrequest, read data steered back by readdatavalid.
// Optional feature macro: OCM_ARB_RANGE_CHECK_EN (out-of-range accesses are
// accepted but not issued, reads return BADDATA, sticky err_irq).
module nios_onchip_mem_arbiter
  import nios_ocm_pkg::*;
#(
  parameter int ADDR_W = OCM_ADDR_W,
  parameter int DATA_W = OCM_DATA_W,
  parameter int DEPTH  = OCM_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  input  logic                mem_stall,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_irq
);

  localparam int BE_W = DATA_W / 8;

  logic              req0_s;
  logic              req1_s;
  logic              gnt_valid_s;
  req_id_t           gnt_id_s;
  logic              accept_s;
  logic              addr_ok_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [BE_W-1:0]   sel_be_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_write_s;
  logic [DATA_W-1:0] rdata_s;

  // Gates waitrequest while in reset and for the first edge after release
  logic              rst_ok_q;
  logic              rst_ok_d;
  logic              rd_pend_q;
  logic              rd_pend_d;
  req_id_t           rd_tag_q;
  req_id_t           rd_tag_d;

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

  nios_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0_s),
    .req1      (req1_s),
    .upd_en    (accept_s),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // A grant is taken only when the RAM is not stalled and reset has settled
  assign accept_s  = gnt_valid_s & ~mem_stall & rst_ok_q;
  assign mem_clken = ~mem_stall;

  // Route the winner's command; with no request this is the m0 value.
  // Read+write together counts as a write.
  always_comb begin
    if (gnt_id_s == ID_M1) begin
      sel_addr_s  = m1_address;
      sel_be_s    = m1_byteenable;
      sel_wdata_s = m1_writedata;
      sel_write_s = m1_write;
    end else begin
      sel_addr_s  = m0_address;
      sel_be_s    = m0_byteenable;
      sel_wdata_s = m0_writedata;
      sel_write_s = m0_write;
    end
  end

`ifdef OCM_ARB_RANGE_CHECK_EN
  logic rd_bad_q;
  logic rd_bad_d;
  logic err_q;
  logic err_d;

  assign addr_ok_s = ({1'b0, sel_addr_s} < (ADDR_W + 1)'(DEPTH));

  // Remember that the pending read was out of range, and latch the error
  always_comb begin
    rd_bad_d = accept_s & ~addr_ok_s & ~sel_write_s;
    err_d    = err_q | (accept_s & ~addr_ok_s);
  end

  // Range-error state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bad_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_bad_q <= rd_bad_d;
      err_q    <= err_d;
    end
  end

  assign rdata_s = rd_bad_q ? DATA_W'(BADDATA) : mem_readdata;
  assign err_irq = err_q;
`else
  assign addr_ok_s = 1'b1;
  assign rdata_s   = mem_readdata;
  assign err_irq   = 1'b0;
`endif

  // Drive the RAM pins and the per-master stall
  always_comb begin
    mem_address    = sel_addr_s;
    mem_byteenable = sel_be_s;
    mem_writedata  = sel_wdata_s;
    mem_chipselect = accept_s & addr_ok_s;
    mem_write      = accept_s & addr_ok_s & sel_write_s;
    m0_waitrequest = ~(accept_s & (gnt_id_s == ID_M0));
    m1_waitrequest = ~(accept_s & (gnt_id_s == ID_M1));
  end

  // Track the read launched this cycle so its data can be steered next cycle
  always_comb begin
    rst_ok_d  = 1'b1;
    rd_pend_d = accept_s & ~sel_write_s;
    if (accept_s) begin
      rd_tag_d = gnt_id_s;
    end else begin
      rd_tag_d = rd_tag_q;
    end
  end

  // Read-return and reset-release state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_ok_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= ID_M0;
    end else begin
      rst_ok_q  <= rst_ok_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  // Data goes to both ports; only the valid strobe is steered
  assign m0_readdata      = rdata_s;
  assign m1_readdata      = rdata_s;
  assign m0_readdatavalid = rd_pend_q & (rd_tag_q == ID_M0);
  assign m1_readdatavalid = rd_pend_q & (rd_tag_q == ID_M1);

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// Directed bench for nios_onchip_mem_arbiter with a RAM model, a
// transaction-level reference model checked every cycle, and literal pins.
module tb_nios_onchip_mem_arbiter;

`ifdef OCM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_stall;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        err_irq;

  always #5 clk = ~clk;

  nios_onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_stall(mem_stall), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata), .err_irq(err_irq)
  );

  // RAM with one-cycle registered read
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model state
  int          m_last  = 1;
  bit          m_ready = 1'b0;
  bit          m_pv    = 1'b0;
  int          m_pp    = 0;
  logic [31:0] m_pd;
  bit          m_err   = 1'b0;
  logic [31:0] sh [0:8191];
  int          win;
  bit          r0, r1, wwr, inr;
  logic [12:0] wa;
  logic [3:0]  wbe;
  logic [31:0] wdat;

  // Every-cycle compare against the model, then advance it to the next edge
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_wait0", {31'd0, m0_waitrequest}, 32'd1);
      chk("rst_wait1", {31'd0, m1_waitrequest}, 32'd1);
      chk("rst_rdv0", {31'd0, m0_readdatavalid}, 32'd0);
      chk("rst_rdv1", {31'd0, m1_readdatavalid}, 32'd0);
      chk("rst_cs", {31'd0, mem_chipselect}, 32'd0);
      chk("rst_err", {31'd0, err_irq}, 32'd0);
      m_last = 1; m_ready = 1'b0; m_pv = 1'b0; m_err = 1'b0;
    end else begin
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      win = -1;
      if (m_ready && !mem_stall) begin
        if (r0 && r1) win = 1 - m_last;
        else if (r0) win = 0;
        else if (r1) win = 1;
      end
      wa   = (win == 1) ? m1_address : m0_address;
      wbe  = (win == 1) ? m1_byteenable : m0_byteenable;
      wdat = (win == 1) ? m1_writedata : m0_writedata;
      wwr  = (win == 1) ? m1_write : m0_write;
      inr  = !RC || (wa < 13'd5000);
      chk("wait0", {31'd0, m0_waitrequest}, {31'd0, win != 0});
      chk("wait1", {31'd0, m1_waitrequest}, {31'd0, win != 1});
      chk("cs", {31'd0, mem_chipselect}, {31'd0, (win >= 0) && inr});
      chk("mwr", {31'd0, mem_write}, {31'd0, (win >= 0) && inr && wwr});
      chk("clken", {31'd0, mem_clken}, {31'd0, !mem_stall});
      if (win >= 0 && inr) begin
        chk("maddr", {19'd0, mem_address}, {19'd0, wa});
        if (wwr) begin
          chk("mwdata", mem_writedata, wdat);
          chk("mbe", {28'd0, mem_byteenable}, {28'd0, wbe});
        end
      end
      chk("rdv0", {31'd0, m0_readdatavalid}, {31'd0, m_pv && m_pp == 0});
      chk("rdv1", {31'd0, m1_readdatavalid}, {31'd0, m_pv && m_pp == 1});
      if (m_pv) chk("rdata", (m_pp == 0) ? m0_readdata : m1_readdata, m_pd);
      chk("err", {31'd0, err_irq}, {31'd0, m_err});
      m_pv = (win >= 0) && !wwr;
      if (m_pv) begin
        m_pp = win;
        m_pd = inr ? sh[wa] : 32'hDEADBEEF;
      end
      if (win >= 0 && wwr && inr)
        for (int b = 0; b < 4; b++)
          if (wbe[b]) sh[wa][b*8 +: 8] = wdat[b*8 +: 8];
      if (win >= 0) begin
        m_last = win;
        if (!inr) m_err = 1'b1;
      end
      m_ready = 1'b1;
    end
  end

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = 13'd0; m0_byteenable = 4'h0; m0_writedata = 32'd0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = 13'd0; m1_byteenable = 4'h0; m1_writedata = 32'd0;
  endtask

  task automatic drv(input int p, input bit rd, input bit wr, input logic [12:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int w0cnt, w1cnt;

  initial begin
    reset_n = 1'b0; mem_stall = 1'b0; idle();
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Single write then read by m0
    idle(); drv(0, 0, 1, 13'h010, 32'hA5A5A5A5, 4'hF);
    @(negedge clk); chk("t1_wr_wait", {31'd0, m0_waitrequest}, 32'd0);
    step();
    idle(); drv(0, 1, 0, 13'h010, 32'd0, 4'hF);
    @(negedge clk); chk("t1_rd_wait", {31'd0, m0_waitrequest}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t1_rdv", {31'd0, m0_readdatavalid}, 32'd1);
    chk("t1_rdata", m0_readdata, 32'hA5A5A5A5);
    step();

    // Contention: preload, leave m1 as last winner, then 4 cycles of both reading
    drv(0, 0, 1, 13'h020, 32'h22222222, 4'hF); step();
    idle(); drv(1, 0, 1, 13'h030, 32'h33333333, 4'hF); step();
    drv(0, 1, 0, 13'h020, 32'd0, 4'hF); drv(1, 1, 0, 13'h030, 32'd0, 4'hF);
    w0cnt = 0; w1cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_order", {31'd0, m0_waitrequest}, (i % 2 == 0) ? 32'd0 : 32'd1);
      w0cnt += int'(m0_waitrequest);
      w1cnt += int'(m1_waitrequest);
      step();
    end
    idle();
    @(negedge clk);
    chk("t2_w0cnt", w0cnt, 32'd2);
    chk("t2_w1cnt", w1cnt, 32'd2);
    chk("t2_last_rdata", m1_readdata, 32'h33333333);
    step();

    // Byte-lane merge, then read followed by a write to the same word
    drv(0, 0, 1, 13'h040, 32'h11223344, 4'hF); step();
    drv(0, 0, 1, 13'h040, 32'h0000FF00, 4'b0010); step();
    drv(0, 1, 0, 13'h040, 32'd0, 4'hF); step();
    idle(); drv(1, 0, 1, 13'h040, 32'h99999999, 4'hF);
    @(negedge clk);
    chk("t3_merge", m0_readdata, 32'h1122FF44);
    step();
    idle(); step();

    // Stall: pending valid still fires, m1 held off for 3 cycles
    drv(1, 0, 1, 13'h050, 32'h50505050, 4'hF); step();
    idle(); drv(0, 1, 0, 13'h010, 32'd0, 4'hF); step();
    idle(); drv(1, 1, 0, 13'h050, 32'd0, 4'hF); mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("t4_pend_valid", {31'd0, m0_readdatavalid}, 32'd1);
      chk("t4_stall_wait", {31'd0, m1_waitrequest}, 32'd1);
      chk("t4_stall_cs", {31'd0, mem_chipselect}, 32'd0);
      step();
    end
    mem_stall = 1'b0;
    @(negedge clk); chk("t4_release_wait", {31'd0, m1_waitrequest}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t4_rdv", {31'd0, m1_readdatavalid}, 32'd1);
    chk("t4_rdata", m1_readdata, 32'h50505050);
    step();

    // Read and write together is a write
    drv(1, 1, 1, 13'h060, 32'h00000066, 4'hF); step();
    idle(); drv(0, 1, 0, 13'h060, 32'd0, 4'hF);
    @(negedge clk); chk("t5_no_rdv", {31'd0, m1_readdatavalid}, 32'd0);
    step();
    idle();
    @(negedge clk); chk("t5_rdata", m0_readdata, 32'h00000066);
    step();

    // Reset with an m0 read in flight
    drv(0, 1, 0, 13'h010, 32'd0, 4'hF); step();
    idle(); reset_n = 1'b0;
    @(negedge clk); chk("t6_discard", {31'd0, m0_readdatavalid}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    drv(0, 1, 0, 13'h020, 32'd0, 4'hF); drv(1, 1, 0, 13'h030, 32'd0, 4'hF);
    @(negedge clk);
    chk("t6_m0_wins", {31'd0, m0_waitrequest}, 32'd0);
    chk("t6_m1_waits", {31'd0, m1_waitrequest}, 32'd1);
    step();
    idle(); step();

`ifdef OCM_ARB_RANGE_CHECK_EN
    // Out-of-range read
    drv(1, 1, 0, 13'h1388, 32'd0, 4'hF);
    @(negedge clk);
    chk("t7_cs", {31'd0, mem_chipselect}, 32'd0);
    chk("t7_wait", {31'd0, m1_waitrequest}, 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t7_rdv", {31'd0, m1_readdatavalid}, 32'd1);
    chk("t7_rdata", m1_readdata, 32'hDEADBEEF);
    chk("t7_err", {31'd0, err_irq}, 32'd1);
    step(); step();
    @(negedge clk); chk("t7_sticky", {31'd0, err_irq}, 32'd1);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
